// File: rtl/peripheral_ram_responder.sv
// rtl/peripheral_ram_responder.sv - memory-side responder of the peripheral RAM bus
//
// Purpose: answers RAM requests from a synchronous single-port array. After reset it
// sweeps INIT_VAL into every word before accepting requests. Reads return through
// a RD_LAT-cycle pipeline; out-of-range accesses set a sticky error flag; accepted
// reads and writes are counted with saturating counters.
//
// Ports:
//   ram_clk        in   1   clock, rising edge
//   ram_rst        in   1   synchronous active-high reset
//   ram_addr       in   AW  request address
//   ram_din        in   DW  write data
//   ram_cen        in   1   chip enable, active low
//   ram_wen        in   2   byte write enables, active low (bit0 low lane, bit1 high lane)
//   ram_dout       out  DW  read data
//   ram_init_done  out  1   init sweep complete, requests accepted
//   ram_err        out  1   sticky out-of-range flag
//   rd_count       out  CW  accepted reads, saturating
//   wr_count       out  CW  accepted writes, saturating
module peripheral_ram_responder #(
  parameter int              AW       = 8,
  parameter int              DW       = 16,
  parameter int              DEPTH    = 256,
  parameter int              RD_LAT   = 1,
  parameter logic [DW-1:0]   INIT_VAL = '0,
  parameter int              CW       = 16
) (
  input  logic          ram_clk,
  input  logic          ram_rst,
  input  logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_din,
  input  logic          ram_cen,
  input  logic [1:0]    ram_wen,
  output logic [DW-1:0] ram_dout,
  output logic          ram_init_done,
  output logic          ram_err,
  output logic [CW-1:0] rd_count,
  output logic [CW-1:0] wr_count
);

  localparam int            HW       = DW / 2;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_ptr;
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_dout;
  logic          r_err;
  logic [CW-1:0] r_rd_cnt;
  logic [CW-1:0] r_wr_cnt;

  logic          w_in_range;
  logic          w_init_we;
  logic          w_rd_fire;
  logic          w_wr_fire;
  logic [DW-1:0] w_rd_data;

  // A fully populated address space can never be out of range.
  if (DEPTH >= (1 << AW)) begin : g_full
    assign w_in_range = 1'b1;
  end else begin : g_partial
    assign w_in_range = (ram_addr < AW'(DEPTH));
  end

  // Out-of-range reads still travel the pipeline so latency is unchanged; they carry 0.
  assign w_rd_data = w_in_range ? r_mem[ram_addr] : '0;

  always_comb begin
    w_state_next = r_state;
    w_init_we    = 1'b0;
    w_rd_fire    = 1'b0;
    w_wr_fire    = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_we = !ram_rst;
        if (!ram_rst && (r_ptr == LAST_PTR)) w_state_next = ST_READY;
      end
      ST_READY: begin
        w_rd_fire = !ram_rst && !ram_cen && (ram_wen == 2'b11);
        w_wr_fire = !ram_rst && !ram_cen && (ram_wen != 2'b11);
      end
    endcase
  end

  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      r_state  <= ST_INIT;
      r_ptr    <= '0;
      r_err    <= 1'b0;
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_init_we) r_ptr <= r_ptr + AW'(1);
      if ((w_rd_fire || w_wr_fire) && !w_in_range) r_err <= 1'b1;
      if (w_rd_fire && (r_rd_cnt != '1)) r_rd_cnt <= r_rd_cnt + CW'(1);
      if (w_wr_fire && (r_wr_cnt != '1)) r_wr_cnt <= r_wr_cnt + CW'(1);
    end
  end

  // Array contents survive reset; only the sweep initialises them.
  always_ff @(posedge ram_clk) begin
    if (w_init_we) begin
      r_mem[r_ptr] <= INIT_VAL;
    end else if (w_wr_fire && w_in_range) begin
      if (!ram_wen[0]) r_mem[ram_addr][HW-1:0]  <= ram_din[HW-1:0];
      if (!ram_wen[1]) r_mem[ram_addr][DW-1:HW] <= ram_din[DW-1:HW];
    end
  end

  if (RD_LAT <= 1) begin : g_lat1
    always_ff @(posedge ram_clk) begin
      if (ram_rst)        r_dout <= '0;
      else if (w_rd_fire) r_dout <= w_rd_data;
    end
  end else begin : g_pipe
    // RD_LAT-1 stages between the array read and ram_dout; a valid bit per stage
    // lets reset discard in-flight reads.
    localparam int NS = RD_LAT - 1;
    logic [NS-1:0] r_pv;
    logic [DW-1:0] r_pd [NS];

    always_ff @(posedge ram_clk) begin
      if (ram_rst) begin
        r_pv   <= '0;
        r_dout <= '0;
      end else begin
        r_pv[0] <= w_rd_fire;
        r_pd[0] <= w_rd_data;
        for (int i = 1; i < NS; i++) begin
          r_pv[i] <= r_pv[i-1];
          r_pd[i] <= r_pd[i-1];
        end
        if (r_pv[NS-1]) r_dout <= r_pd[NS-1];
      end
    end
  end

  assign ram_dout      = r_dout;
  assign ram_init_done = (r_state == ST_READY);
  assign ram_err       = r_err;
  assign rd_count      = r_rd_cnt;
  assign wr_count      = r_wr_cnt;

endmodule

// File: tb/tb_peripheral_ram_responder.sv
// tb/tb_peripheral_ram_responder.sv - self-checking bench for peripheral_ram_responder
module tb_peripheral_ram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic [15:0] din;
  logic        cen;
  logic [1:0]  wen;

  logic [15:0] a_dout, b_dout, c_dout, d_dout;
  logic        a_done, b_done, c_done, d_done;
  logic        a_err, b_err, c_err, d_err;
  logic [15:0] a_rd, a_wr, c_rd, c_wr, d_rd, d_wr;
  logic [1:0]  b_rd, b_wr;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  peripheral_ram_responder #(.AW(8), .DW(16), .DEPTH(256), .RD_LAT(1), .INIT_VAL(16'h0), .CW(16)) u_a (
    .ram_clk(clk), .ram_rst(rst), .ram_addr(addr), .ram_din(din), .ram_cen(cen), .ram_wen(wen),
    .ram_dout(a_dout), .ram_init_done(a_done), .ram_err(a_err), .rd_count(a_rd), .wr_count(a_wr));

  peripheral_ram_responder #(.AW(8), .DW(16), .DEPTH(200), .RD_LAT(2), .INIT_VAL(16'h0), .CW(2)) u_b (
    .ram_clk(clk), .ram_rst(rst), .ram_addr(addr), .ram_din(din), .ram_cen(cen), .ram_wen(wen),
    .ram_dout(b_dout), .ram_init_done(b_done), .ram_err(b_err), .rd_count(b_rd), .wr_count(b_wr));

  peripheral_ram_responder #(.AW(8), .DW(16), .DEPTH(256), .RD_LAT(3), .INIT_VAL(16'h0), .CW(16)) u_c (
    .ram_clk(clk), .ram_rst(rst), .ram_addr(addr), .ram_din(din), .ram_cen(cen), .ram_wen(wen),
    .ram_dout(c_dout), .ram_init_done(c_done), .ram_err(c_err), .rd_count(c_rd), .wr_count(c_wr));

  peripheral_ram_responder #(.AW(8), .DW(16), .DEPTH(256), .RD_LAT(4), .INIT_VAL(16'h0), .CW(16)) u_d (
    .ram_clk(clk), .ram_rst(rst), .ram_addr(addr), .ram_din(din), .ram_cen(cen), .ram_wen(wen),
    .ram_dout(d_dout), .ram_init_done(d_done), .ram_err(d_err), .rd_count(d_rd), .wr_count(d_wr));

  typedef struct {
    logic        cen;
    logic [1:0]  wen;
    logic [7:0]  addr;
    logic [15:0] din;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sat3(input int x);
    return (x > 3) ? 32'd3 : 32'(x);
  endfunction

  int ka, kb;
  logic [15:0] ea [7];
  logic [15:0] eb [7];
  logic [15:0] ec [7];
  logic [15:0] ed [7];

  initial begin
    // cen wen addr din exp_a exp_b rd wr
    tbl[0]  = '{1'b0, 2'b11, 8'h10, 16'h0000, 16'h0000, 16'h0000, 1, 0};
    tbl[1]  = '{1'b0, 2'b00, 8'h05, 16'hA55A, 16'h0000, 16'h0000, 1, 1};
    tbl[2]  = '{1'b0, 2'b11, 8'h05, 16'h0000, 16'hA55A, 16'hA55A, 2, 1};
    tbl[3]  = '{1'b0, 2'b00, 8'h07, 16'h1234, 16'hA55A, 16'hA55A, 2, 2};
    tbl[4]  = '{1'b0, 2'b10, 8'h07, 16'hFFCD, 16'hA55A, 16'hA55A, 2, 3};
    tbl[5]  = '{1'b0, 2'b11, 8'h07, 16'h0000, 16'h12CD, 16'h12CD, 3, 3};
    tbl[6]  = '{1'b0, 2'b01, 8'h07, 16'hAB00, 16'h12CD, 16'h12CD, 3, 4};
    tbl[7]  = '{1'b0, 2'b11, 8'h07, 16'h0000, 16'hABCD, 16'hABCD, 4, 4};
    tbl[8]  = '{1'b0, 2'b00, 8'hF0, 16'hBEEF, 16'hABCD, 16'hABCD, 4, 5};
    tbl[9]  = '{1'b0, 2'b11, 8'hF0, 16'h0000, 16'hBEEF, 16'h0000, 5, 5};
    tbl[10] = '{1'b0, 2'b11, 8'h05, 16'h0000, 16'hA55A, 16'hA55A, 6, 5};
    tbl[11] = '{1'b0, 2'b00, 8'h01, 16'h0011, 16'hA55A, 16'hA55A, 6, 6};
    tbl[12] = '{1'b0, 2'b00, 8'h02, 16'h0022, 16'hA55A, 16'hA55A, 6, 7};
    tbl[13] = '{1'b0, 2'b00, 8'h03, 16'h0033, 16'hA55A, 16'hA55A, 6, 8};
    tbl[14] = '{1'b1, 2'b00, 8'h05, 16'h0000, 16'hA55A, 16'hA55A, 6, 8};

    // Reset with a write request held on the bus; it must be ignored through init.
    rst = 1'b1; cen = 1'b0; wen = 2'b00; addr = 8'h10; din = 16'hDEAD;
    repeat (3) tick();
    chk("rst_dout",  32'(a_dout), 32'h0);
    chk("rst_done",  32'(a_done), 32'h0);
    chk("rst_err",   32'(a_err),  32'h0);
    chk("rst_rdcnt", 32'(a_rd),   32'h0);
    chk("rst_wrcnt", 32'(a_wr),   32'h0);

    rst = 1'b0;
    ka = 0; kb = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (b_done && kb == 0) kb = k;
      if (b_done) cen = 1'b1;
      if (a_done && ka == 0) ka = k;
      if (ka != 0) break;
    end
    chk("init_edges_256", 32'(ka), 32'd256);
    chk("init_edges_200", 32'(kb), 32'd200);
    chk("init_wr_ignored_a", 32'(a_wr), 32'h0);
    chk("init_wr_ignored_b", 32'(b_wr), 32'h0);
    chk("init_err", 32'(a_err), 32'h0);

    for (int i = 0; i < 15; i++) begin
      cen = tbl[i].cen; wen = tbl[i].wen; addr = tbl[i].addr; din = tbl[i].din;
      tick();
      cen = 1'b1;
      repeat (4) tick();
      chk($sformatf("vec%0d_dout_a", i), 32'(a_dout), 32'(tbl[i].exp_a));
      chk($sformatf("vec%0d_dout_b", i), 32'(b_dout), 32'(tbl[i].exp_b));
      chk($sformatf("vec%0d_dout_c", i), 32'(c_dout), 32'(tbl[i].exp_a));
      chk($sformatf("vec%0d_dout_d", i), 32'(d_dout), 32'(tbl[i].exp_a));
      chk($sformatf("vec%0d_rdcnt_a", i), 32'(a_rd), 32'(tbl[i].exp_rd));
      chk($sformatf("vec%0d_wrcnt_a", i), 32'(a_wr), 32'(tbl[i].exp_wr));
      chk($sformatf("vec%0d_rdcnt_b", i), 32'(b_rd), sat3(tbl[i].exp_rd));
    end

    repeat (10) tick();
    chk("err_sticky_b", 32'(b_err), 32'h1);
    chk("err_clear_a",  32'(a_err), 32'h0);

    // Back-to-back reads of 0x01..0x03, observed per edge on every latency.
    ea = '{16'h0011, 16'h0022, 16'h0033, 16'h0033, 16'h0033, 16'h0033, 16'h0033};
    eb = '{16'hA55A, 16'h0011, 16'h0022, 16'h0033, 16'h0033, 16'h0033, 16'h0033};
    ec = '{16'hA55A, 16'hA55A, 16'h0011, 16'h0022, 16'h0033, 16'h0033, 16'h0033};
    ed = '{16'hA55A, 16'hA55A, 16'hA55A, 16'h0011, 16'h0022, 16'h0033, 16'h0033};
    for (int t = 0; t < 7; t++) begin
      if (t < 3) begin
        cen = 1'b0; wen = 2'b11; addr = 8'(t + 1);
      end else begin
        cen = 1'b1;
      end
      tick();
      chk($sformatf("pipe_t%0d_a", t), 32'(a_dout), 32'(ea[t]));
      chk($sformatf("pipe_t%0d_b", t), 32'(b_dout), 32'(eb[t]));
      chk($sformatf("pipe_t%0d_c", t), 32'(c_dout), 32'(ec[t]));
      chk($sformatf("pipe_t%0d_d", t), 32'(d_dout), 32'(ed[t]));
    end

    // Read-after-write on the next edge.
    cen = 1'b0; wen = 2'b00; addr = 8'h09; din = 16'h5678;
    tick();
    wen = 2'b11;
    tick();
    chk("raw_a", 32'(a_dout), 32'h5678);
    cen = 1'b1;
    repeat (4) tick();
    chk("raw_b", 32'(b_dout), 32'h5678);
    chk("raw_d", 32'(d_dout), 32'h5678);

    // Reset one cycle after a read: the 4-cycle read must never surface.
    cen = 1'b0; wen = 2'b11; addr = 8'h05;
    tick();
    cen = 1'b1; rst = 1'b1;
    tick();
    chk("midrst_dout_d", 32'(d_dout), 32'h0);
    chk("midrst_done",   32'(a_done), 32'h0);
    chk("midrst_err_b",  32'(b_err),  32'h0);
    chk("midrst_rdcnt",  32'(a_rd),   32'h0);
    rst = 1'b0;
    ka = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k <= 6) begin
        chk($sformatf("midrst_hold%0d_d", k), 32'(d_dout), 32'h0);
        chk($sformatf("midrst_hold%0d_c", k), 32'(c_dout), 32'h0);
      end
      if (a_done && ka == 0) ka = k;
      if (ka != 0) break;
    end
    chk("reinit_edges_256", 32'(ka), 32'd256);

    // Five writes saturate the 2-bit counter at 3.
    for (int i = 0; i < 5; i++) begin
      cen = 1'b0; wen = 2'b00; addr = 8'h20; din = 16'(i);
      tick();
    end
    cen = 1'b1;
    tick();
    chk("sat_wrcnt_b", 32'(b_wr), 32'd3);
    chk("sat_wrcnt_a", 32'(a_wr), 32'd5);
    chk("sat_rdcnt_b", 32'(b_rd), 32'd0);
    cen = 1'b0; wen = 2'b11; addr = 8'h20;
    tick();
    cen = 1'b1;
    chk("sat_last_write", 32'(a_dout), 32'h4);
    cen = 1'b0; addr = 8'h10;
    tick();
    cen = 1'b1;
    chk("reinit_rd10", 32'(a_dout), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
